// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/chunk_serial_adder_if.sv
// Start/done request bus of the chunk-serial adder.
interface chunk_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  ready, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, done, s, cout, ovf
  );
endinterface

// File: rtl/chunk_serial_adder_ripple.sv
// CHUNK-bit combinational ripple slice built from full-adder cells.
module onebitadder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    onebitadder u_cell (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (c[i]),
      .sum_o (sum_o[i]),
      .cout_o(c[i+1])
    );
  end

  assign cout_o  = c[CHUNK];
  // carry entering the slice's top bit; on the last chunk this is the carry into the word MSB
  assign c_msb_o = c[CHUNK-1];
endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LS chunk first.
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunk_serial_adder_if.slave  bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_param
    $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .a_i    (a_q[idx_q*CHUNK +: CHUNK]),
    .b_i    (b_q[idx_q*CHUNK +: CHUNK]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .c_msb_o(slice_c_msb)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: accept in IDLE/DONE, one chunk per RUN edge, flags on the last chunk.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          ovf_d   = slice_c_msb ^ slice_cout;
          state_d = DONE;
        end
      end
      default: begin
        if (bus.start) begin
          // subtraction is a + ~b + 1, so the inversion and the +1 are folded in here
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.ready = (state_q != RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench: CHUNK=4 and CHUNK=16 instances checked against an arithmetic model.
module tb_chunk_serial_adder;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pcyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t q4[$];
  exp_t q16[$];
  exp_t e4, e16;

  chunk_serial_adder_if #(.WIDTH(W)) bus4 ();
  chunk_serial_adder_if #(.WIDTH(W)) bus16 ();

  chunk_serial_adder #(.WIDTH(W), .CHUNK(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  chunk_serial_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    int          sa, sb, sr;
    logic [W:0]  u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = {1'b0, a} - {1'b0, b};
      sr = sa - sb;
      e.cout = (a >= b);
    end else begin
      u = {1'b0, a} + {1'b0, b} + 17'(cin);
      sr = sa + sb + int'(cin);
      e.cout = u[W];
    end
    e.s   = u[W-1:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    e.due = 0;
    return e;
  endfunction

  // Monitors: pop an expectation whenever done is seen.
  always @(negedge clk) begin
    if (rst_n && bus4.done) begin
      if (q4.size() == 0) check("done4_unexpected", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("s4", bus4.s, e4.s);
        check("cout4", bus4.cout, e4.cout);
        check("ovf4", bus4.ovf, e4.ovf);
        check("latency4", pcyc, e4.due);
        check("ready4_in_done", bus4.ready, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus16.done) begin
      if (q16.size() == 0) check("done16_unexpected", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("s16", bus16.s, e16.s);
        check("cout16", bus16.cout, e16.cout);
        check("ovf16", bus16.ovf, e16.ovf);
        check("latency16", pcyc, e16.due);
      end
    end
  end

  // Issue one op on the CHUNK=4 unit; noise drives ignored starts while busy.
  task automatic do_op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int gap, input bit noise);
    exp_t e;
    int   w;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
    end
    w = 0;
    @(negedge clk);
    while (!bus4.ready) begin
      if (noise) begin
        bus4.start = 1'b1;
        bus4.a     = 16'($urandom);
        bus4.b     = 16'($urandom);
        bus4.cin   = 1'($urandom);
        bus4.sub   = 1'($urandom);
      end else begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
      w++;
      if (w > 50) begin
        check("ready4_timeout", 0, 1);
        return;
      end
    end
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = cin;
    bus4.sub   = sub;
    e = model(a, b, cin, sub);
    e.due = pcyc + 4 + 1;
    q4.push_back(e);
  endtask

  task automatic do_op16(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!bus16.ready) begin
      bus16.start = 1'b0;
      @(negedge clk);
      w++;
      if (w > 50) begin
        check("ready16_timeout", 0, 1);
        return;
      end
    end
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    bus16.cin   = cin;
    bus16.sub   = sub;
    e = model(a, b, cin, sub);
    e.due = pcyc + 1 + 1;
    q16.push_back(e);
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    bus4.start  = 1'b0;
    bus16.start = 1'b0;
    while ((q4.size() != 0 || q16.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain4", q4.size(), 0);
    check("drain16", q16.size(), 0);
  endtask

  task automatic check_reset4(input string tag);
    check({tag, "_ready"}, bus4.ready, 1);
    check({tag, "_done"}, bus4.done, 0);
    check({tag, "_s"}, bus4.s, 0);
    check({tag, "_cout"}, bus4.cout, 0);
    check({tag, "_ovf"}, bus4.ovf, 0);
  endtask

  logic [W-1:0] da [5] = '{16'hFFFF, 16'h7FFF, 16'h000F, 16'h0005, 16'h8000};
  logic [W-1:0] db [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
  logic         dc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] corner [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h00FF};

  initial begin
    bus4.start = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;  bus4.sub = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    #1;
    check_reset4("reset4");
    check("reset16_ready", bus16.ready, 1);
    check("reset16_done", bus16.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) do_op4(da[i], db[i], dc[i], ds[i], 1, 0);
    drain();

    // Back-to-back with ignored starts during RUN.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      do_op4(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end
    drain();

    // Async reset mid-run.
    do_op4(16'h1111, 16'h2222, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset4("midrun_reset4");
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 0);
    do_op4(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1);
    drain();

    do_op16(16'h1234, 16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
